config_access_arbiter: RTL

Arbiter and sequencer placed in front of the control unit's 35-bit configuration register. It shares the single configuration write port among `NREQ` requesters and grants one requester at a time in round-robin order. Each write is authenticated against `syskey`, and the block locks out after repeated bad passwords. Only an authenticated write pulses `write_en` and updates `configout`.

---
 rtl/config_arb_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/config_access_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/config_arb_pkg.sv
// config_arb_pkg
// Shared definitions for the configuration access arbiter:
//   - state_e     : sequencer state encoding (also exported on dbg_state)
//   - *_DEF       : default requester count and word widths
//   - next_index  : round-robin successor with wrap-around
package config_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_WRITE   = 3'd2,
    S_RELEASE = 3'd3,
    S_LOCKED  = 3'd4
  } state_e;

  localparam int NREQ_DEF  = 4;
  localparam int CFG_W_DEF = 35;
  localparam int KEY_W_DEF = 2;

  // Successor of idx in a ring of n requesters.
  function automatic int next_index(input int idx, input int n);
    if (idx >= n - 1) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker: returns the first asserted
// request found searching upward from ptr, wrapping at NREQ-1 -> 0.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  IDXW  search start index (must be < NREQ)
//   pick  out NREQ  one-hot of the chosen requester (zero if none)
//   idx   out IDXW  binary index of the chosen requester
//   valid out 1     at least one request is asserted
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] pick,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  // Scan the ring starting at ptr; the first hit wins.
  always_comb begin
    logic [IDXW-1:0] cand_s;
    pick   = '0;
    idx    = '0;
    valid  = 1'b0;
    cand_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IDXW'((int'(ptr) + k) % NREQ);
      if (!valid && req[cand_s]) begin
        valid        = 1'b1;
        pick[cand_s] = 1'b1;
        idx          = cand_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/config_access_arbiter.sv
// config_access_arbiter
// Shares the single configuration write port among NREQ requesters in
// round-robin order, authenticates each commit against syskey and locks
// out for LOCK_CYC cycles after MAX_FAIL consecutive bad passwords.
// Ports:
//   clk, arst             clock, asynchronous active-low reset
//   req/confirm [NREQ]    per-requester level request / commit strobe
//   password, configin    per-requester packed slices (slice i = requester i)
//   syskey                system key
//   grant [NREQ]          registered one-hot grant (zero in IDLE/LOCKED)
//   configout [CFG_W]     committed configuration word
//   write_en, denied      one-cycle commit / rejection pulses
//   locked                high while in lockout
//   dbg_state [3]         current state encoding
module config_access_arbiter
  import config_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int CFG_W    = CFG_W_DEF,
  parameter int KEY_W    = KEY_W_DEF,
  parameter int TIMEOUT  = 8,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         confirm,
  input  logic [NREQ*KEY_W-1:0]   password,
  input  logic [NREQ*CFG_W-1:0]   configin,
  input  logic [KEY_W-1:0]        syskey,
  output logic [NREQ-1:0]         grant,
  output logic [CFG_W-1:0]        configout,
  output logic                    write_en,
  output logic                    denied,
  output logic                    locked,
  output logic [2:0]              dbg_state
);

  localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FAILW = $clog2(MAX_FAIL + 1);
  localparam int TMRW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LCKW  = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

  localparam logic [TMRW-1:0]  TMR_LAST = TMRW'(TIMEOUT - 1);
  localparam logic [LCKW-1:0]  LCK_LAST = LCKW'(LOCK_CYC - 1);
  localparam logic [FAILW-1:0] FAIL_LIM = FAILW'(MAX_FAIL);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [FAILW-1:0] fail_q, fail_d;
  logic [TMRW-1:0]  timer_q, timer_d;
  logic [LCKW-1:0]  lock_q, lock_d;
  logic             denied_q, denied_d;

  logic [NREQ-1:0]  pick_s;
  logic [IDXW-1:0]  pick_idx_s;
  logic             pick_valid_s;
  logic [KEY_W-1:0] key_sel_s;
  logic [CFG_W-1:0] cfg_sel_s;
  logic [IDXW-1:0]  ptr_next_s;
  logic [FAILW-1:0] fail_inc_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick_s),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  // Only the granted requester's slices are ever looked at.
  assign key_sel_s  = password[int'(idx_q) * KEY_W +: KEY_W];
  assign cfg_sel_s  = configin[int'(idx_q) * CFG_W +: CFG_W];
  assign ptr_next_s = IDXW'(next_index(int'(idx_q), NREQ));
  assign fail_inc_s = fail_q + FAILW'(1);

  // Next-state and datapath decisions for the access sequencer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    cfg_d    = cfg_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    lock_d   = lock_q;
    denied_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid_s) begin
          grant_d = pick_s;
          idx_d   = pick_idx_s;
          timer_d = '0;
          state_d = S_GRANT;
        end else begin
          grant_d = '0;
        end
      end

      S_GRANT: begin
        // Withdrawal wins over a same-cycle confirm; the pointer stays put.
        if (!req[idx_q]) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (confirm[idx_q]) begin
          if (key_sel_s == syskey) begin
            cfg_d   = cfg_sel_s;
            state_d = S_WRITE;
          end else begin
            denied_d = 1'b1;
            fail_d   = fail_inc_s;
            ptr_d    = ptr_next_s;
            grant_d  = '0;
            if (fail_inc_s >= FAIL_LIM) begin
              lock_d  = '0;
              state_d = S_LOCKED;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (timer_q == TMR_LAST) begin
          denied_d = 1'b1;
          ptr_d    = ptr_next_s;
          grant_d  = '0;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + TMRW'(1);
        end
      end

      S_WRITE: begin
        fail_d  = '0;
        ptr_d   = ptr_next_s;
        state_d = S_RELEASE;
      end

      S_RELEASE: begin
        // Confirm is deliberately ignored here so a held strobe cannot rewrite.
        if (!req[idx_q]) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_RELEASE;
        end
      end

      S_LOCKED: begin
        grant_d = '0;
        if (lock_q == LCK_LAST) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          lock_d = lock_q + LCKW'(1);
        end
      end

      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state, counters and committed configuration register.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      cfg_q    <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
      lock_q   <= '0;
      denied_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cfg_q    <= cfg_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      lock_q   <= lock_d;
      denied_q <= denied_d;
    end
  end

  // Pulses are pure decodes of registered state: no input-to-output path.
  assign grant     = grant_q;
  assign configout = cfg_q;
  assign denied    = denied_q;
  assign write_en  = (state_q == S_WRITE);
  assign locked    = (state_q == S_LOCKED);
  assign dbg_state = state_q;

endmodule
